// File: rtl/matrix_pkg.sv
// Shared widths and field layout for one buffered lane result {val, x, y}.
// Latency: none (declarations only).
// Backpressure: not applicable.
package matrix_pkg;

  localparam int MAX_WIDTH_LEN = 4;
  localparam int SIZE_VALUE    = 16;

  // Entry layout, LSB first: y, then x, then the signed value on top.
  localparam int ENTRY_W = SIZE_VALUE + 2 * MAX_WIDTH_LEN;
  localparam int Y_OFF   = 0;
  localparam int X_OFF   = MAX_WIDTH_LEN;
  localparam int VAL_OFF = 2 * MAX_WIDTH_LEN;

  // The same layout for any coordinate/value width chosen by the instantiator.
  function automatic int entry_width(input int mw, input int sv);
    return sv + 2 * mw;
  endfunction

  function automatic int x_offset(input int mw);
    return mw;
  endfunction

  function automatic int val_offset(input int mw);
    return 2 * mw;
  endfunction

endpackage

// File: rtl/collector_fifo.sv
// Per-lane synchronous FIFO, 2^DEPTH_LEN entries, head visible on dout.
// Latency: a pushed entry appears on dout the cycle after the push edge.
// Backpressure: full is a flop; a push while full is taken only if popped in the same edge.
module collector_fifo #(
  parameter int WIDTH     = 24,
  parameter int DEPTH_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LEN;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LEN-1:0] wr_ptr;
  logic [DEPTH_LEN-1:0] rd_ptr;
  logic [DEPTH_LEN:0]   count;
  logic [DEPTH_LEN:0]   count_next;
  logic                 do_push;
  logic                 do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Occupancy after this edge; full is registered from it so it has no comb path from push/pop.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) count_next = count + 1'b1;
    if (do_pop && !do_push) count_next = count - 1'b1;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (DEPTH_LEN+1)'(DEPTH));
    end
  end

  // Storage array; contents are don't-care while empty so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/matrix_result_collector.sv
// Merges CHANNELS lane results via per-lane FIFOs and a round-robin arbiter into one tagged stream.
// Latency: input sampled at edge k appears with rdy=1 after edge k+1; 1 result/cycle sustained.
// Backpressure: rdy/out held while out_ack=0; full lanes drop pushes (counted when COLLECT_OVF_CNT_EN is defined).
module matrix_result_collector
  import matrix_pkg::*;
#(
  parameter int CHANNELS    = 5,
  parameter int maxWidthLen = MAX_WIDTH_LEN,
  parameter int sizeValue   = SIZE_VALUE,
  parameter int DEPTH_LEN   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNELS-1:0]               in_rdy,
  input  logic [CHANNELS*sizeValue-1:0]     in_val,
  input  logic [CHANNELS*maxWidthLen-1:0]   in_x,
  input  logic [CHANNELS*maxWidthLen-1:0]   in_y,
  output logic [CHANNELS-1:0]               in_full,
  input  logic                              out_ack,
  output logic                              rdy,
  output logic signed [sizeValue-1:0]       out,
  output logic [maxWidthLen-1:0]            ox,
  output logic [maxWidthLen-1:0]            oy,
  output logic                              busy
`ifdef COLLECT_OVF_CNT_EN
  ,
  output logic [15:0]                       ovf_cnt
`endif
);

  localparam int EW   = entry_width(maxWidthLen, sizeValue);
  localparam int XO   = x_offset(maxWidthLen);
  localparam int VO   = val_offset(maxWidthLen);
  localparam int PW   = $clog2(CHANNELS);

  logic [EW-1:0]       head [CHANNELS];
  logic [CHANNELS-1:0] nonempty;
  logic [CHANNELS-1:0] pop;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       grant;
  logic                found;
  logic                load;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic [EW-1:0] din;
      logic          empty;

      assign din = {in_val[gi*sizeValue +: sizeValue],
                    in_x[gi*maxWidthLen +: maxWidthLen],
                    in_y[gi*maxWidthLen +: maxWidthLen]};
      assign nonempty[gi] = !empty;
      assign pop[gi]      = load && (grant == PW'(gi));

      collector_fifo #(
        .WIDTH     (EW),
        .DEPTH_LEN (DEPTH_LEN)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_rdy[gi]),
        .pop   (pop[gi]),
        .din   (din),
        .dout  (head[gi]),
        .full  (in_full[gi]),
        .empty (empty)
      );
    end
  endgenerate

  // Round-robin search: first non-empty lane starting at rr_ptr, wrapping past the top lane.
  always_comb begin
    int          idx;
    logic [PW-1:0] idx_l;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    idx_l = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      idx_l = PW'(idx);
      if (!found && nonempty[idx_l]) begin
        found = 1'b1;
        grant = idx_l;
      end
    end
  end

  assign load = (!rdy || out_ack) && found;
  assign busy = rdy | (|nonempty);

  // Output register and arbiter pointer; the pointer moves only when a lane is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy    <= 1'b0;
      out    <= '0;
      ox     <= '0;
      oy     <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      rdy    <= 1'b1;
      out    <= head[grant][VO +: sizeValue];
      ox     <= head[grant][XO +: maxWidthLen];
      oy     <= head[grant][0 +: maxWidthLen];
      rr_ptr <= (grant == PW'(CHANNELS-1)) ? '0 : grant + 1'b1;
    end else if (out_ack) begin
      rdy    <= 1'b0;
    end
  end

`ifdef COLLECT_OVF_CNT_EN
  logic [16:0] ovf_sum;

  // Sum of this cycle's dropped pushes: lane full and not being drained this edge.
  always_comb begin
    ovf_sum = {1'b0, ovf_cnt};
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_rdy[i] && in_full[i] && !pop[i]) ovf_sum = ovf_sum + 17'd1;
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) ovf_cnt <= '0;
    else     ovf_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
  end
`endif

endmodule
